// File: rtl/data_memory_ctrl.sv
// Data-memory controller for the pipeline memory stage: single outstanding
// load/store with fixed LATENCY, byte/word access, misalignment error and
// load cancellation on pipeline flush.
//
//   state | meaning
//   IDLE  | ready for a new request
//   WAIT  | request latched, latency down-counter running
//   RESP  | completion cycle: done_o pulse, store commits at the end
module data_memory_ctrl #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic        clk_i,
    input  logic        reset_n_i,
    input  logic        valid_i,
    input  logic        r_not_w_i,
    input  logic        byte_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_i,
    input  logic        flush_i,
    output logic        ready_o,
    output logic        done_o,
    output logic [31:0] data_o,
    output logic        err_o
);
    localparam int         AW       = $clog2(DEPTH);
    localparam logic [2:0] CNT_INIT = 3'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic [2:0]    r_cnt;
    logic [2:0]    w_cnt_next;

    logic          r_rnw;
    logic          r_byte;
    logic [AW+1:0] r_addr;
    logic [31:0]   r_wdata;
    logic [31:0]   r_mem [DEPTH];

    logic          w_accept;
    logic          w_misalign;
    logic          w_load_flush;
    logic          w_commit;
    logic          w_done;
    logic [AW-1:0] w_idx;
    logic [1:0]    w_lane;
    logic [31:0]   w_word;
    logic [7:0]    w_byte;
    logic          w_unused_addr;

    // Address bits above the array span wrap away by design.
    assign w_unused_addr = &{1'b0, data_addr_i[31:AW+2]};

    assign w_accept     = valid_i & ready_o & ~flush_i;
    assign w_misalign   = ~r_byte & (r_addr[1:0] != 2'b00);
    assign w_idx        = r_addr[AW+1:2];
    assign w_lane       = r_addr[1:0];
    assign w_word       = r_mem[w_idx];
    assign w_load_flush = r_rnw & flush_i;
    // A reset arriving in RESP must drop the store rather than commit it.
    assign w_commit     = reset_n_i & (r_state == RESP) & ~r_rnw & ~w_misalign;

    // State register and latency down-counter.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            r_state <= IDLE;
            r_cnt   <= 3'd0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Next-state logic and outputs; all outputs held low while in reset.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_done       = 1'b0;
        w_byte       = 8'd0;
        ready_o      = 1'b0;
        done_o       = 1'b0;
        err_o        = 1'b0;
        data_o       = 32'd0;

        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (LATENCY == 1) begin
                        w_state_next = RESP;
                    end else begin
                        w_state_next = WAIT;
                        w_cnt_next   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                if (w_load_flush) begin
                    w_state_next = IDLE;
                    w_cnt_next   = 3'd0;
                end else if (r_cnt == 3'd1) begin
                    w_state_next = RESP;
                    w_cnt_next   = 3'd0;
                end else begin
                    w_cnt_next = r_cnt - 3'd1;
                end
            end
            RESP: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
                w_cnt_next   = 3'd0;
            end
        endcase

        case (w_lane)
            2'd0:    w_byte = w_word[7:0];
            2'd1:    w_byte = w_word[15:8];
            2'd2:    w_byte = w_word[23:16];
            default: w_byte = w_word[31:24];
        endcase

        // A flushed load completing in RESP is silently cancelled.
        w_done  = reset_n_i & (r_state == RESP) & ~w_load_flush;
        ready_o = reset_n_i & (r_state == IDLE);
        done_o  = w_done;
        err_o   = w_done & w_misalign;
        if (w_done && r_rnw && !w_misalign) begin
            data_o = r_byte ? {24'd0, w_byte} : w_word;
        end
    end

    // Capture the request on accept so later input changes are ignored.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            r_rnw   <= 1'b1;
            r_byte  <= 1'b0;
            r_addr  <= '0;
            r_wdata <= 32'd0;
        end else if (w_accept) begin
            r_rnw   <= r_not_w_i;
            r_byte  <= byte_i;
            r_addr  <= data_addr_i[AW+1:0];
            r_wdata <= data_i;
        end
    end

    // Array write on the edge ending RESP; contents survive reset.
    always_ff @(posedge clk_i) begin
        if (w_commit) begin
            if (r_byte) begin
                r_mem[w_idx][{w_lane, 3'b000} +: 8] <= r_wdata[7:0];
            end else begin
                r_mem[w_idx] <= r_wdata;
            end
        end
    end

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Self-checking bench for data_memory_ctrl: directed scenarios plus a
// randomized load/store/flush mix checked against a word-array model.
module tb_data_memory_ctrl;
    localparam int DEPTH = 256;
    localparam int L     = 2;
    localparam int AW    = $clog2(DEPTH);

    logic        clk_i = 1'b0;
    logic        reset_n_i;
    logic        valid_i;
    logic        r_not_w_i;
    logic        byte_i;
    logic [31:0] data_addr_i;
    logic [31:0] data_i;
    logic        flush_i;
    logic        ready_o;
    logic        done_o;
    logic [31:0] data_o;
    logic        err_o;

    int          n_cmp;
    int          n_err;
    logic [31:0] mm [DEPTH];

    data_memory_ctrl #(.DEPTH(DEPTH), .LATENCY(L)) dut (
        .clk_i       (clk_i),
        .reset_n_i   (reset_n_i),
        .valid_i     (valid_i),
        .r_not_w_i   (r_not_w_i),
        .byte_i      (byte_i),
        .data_addr_i (data_addr_i),
        .data_i      (data_i),
        .flush_i     (flush_i),
        .ready_o     (ready_o),
        .done_o      (done_o),
        .data_o      (data_o),
        .err_o       (err_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] model_read(input logic [31:0] a, input logic b);
        logic [AW-1:0] idx;
        int            sh;
        logic [31:0]   w;
        idx = AW'((a >> 2) % DEPTH);
        sh  = 8 * int'(a % 4);
        w   = mm[idx];
        if (b) return (w >> sh) & 32'hFF;
        return w;
    endfunction

    function automatic void model_write(input logic [31:0] a, input logic b, input logic [31:0] d);
        logic [AW-1:0] idx;
        int            sh;
        logic [31:0]   m;
        idx = AW'((a >> 2) % DEPTH);
        sh  = 8 * int'(a % 4);
        if (b) begin
            m       = 32'hFF << sh;
            mm[idx] = (mm[idx] & ~m) | ((d & 32'hFF) << sh);
        end else if (a % 4 == 0) begin
            mm[idx] = d;
        end
    endfunction

    // Issue one request, then observe LATENCY+3 cycles; fc = cycle to flush in.
    task automatic access(input logic rnw, input logic byt, input logic [31:0] addr,
                          input logic [31:0] wdata, input int fc,
                          output int dc, output int dn, output logic [31:0] rd,
                          output logic re, output int rc, output logic stray, output logic to);
        int w;
        dc = -1; dn = 0; rd = 32'd0; re = 1'b0; rc = -1; stray = 1'b0; to = 1'b0;
        w  = 0;
        @(negedge clk_i);
        while (ready_o !== 1'b1 && w < 30) begin
            @(negedge clk_i);
            w++;
        end
        if (ready_o !== 1'b1) begin
            to = 1'b1;
            return;
        end
        valid_i = 1'b1; r_not_w_i = rnw; byte_i = byt; data_addr_i = addr; data_i = wdata; flush_i = 1'b0;
        @(posedge clk_i); #1;
        valid_i     = 1'b0;
        r_not_w_i   = 1'($urandom);
        byte_i      = 1'($urandom);
        data_addr_i = $urandom;
        data_i      = $urandom;
        flush_i     = (fc == 1);
        for (int k = 1; k <= L + 3; k++) begin
            @(negedge clk_i);
            if (done_o === 1'b1) begin
                dn++;
                if (dc < 0) begin
                    dc = k; rd = data_o; re = err_o;
                end
            end else if (data_o !== 32'd0 || err_o !== 1'b0) begin
                stray = 1'b1;
            end
            if (ready_o === 1'b1 && rc < 0) rc = k;
            @(posedge clk_i); #1;
            flush_i = (fc == k + 1);
        end
        flush_i = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) begin
            @(negedge clk_i);
            n_cmp++;
            if ({ready_o, done_o, err_o, data_o} !== 35'd0) begin
                n_err++;
                $display("FAIL reset_outputs: got ready=%0b done=%0b err=%0b data=%h, expected all 0",
                         ready_o, done_o, err_o, data_o);
            end
        end
        @(posedge clk_i); #1;
        reset_n_i = 1'b1;
        @(negedge clk_i);
        n_cmp++;
        if (ready_o !== 1'b1 || done_o !== 1'b0) begin
            n_err++;
            $display("FAIL reset_release: got ready=%0b done=%0b, expected ready=1 done=0", ready_o, done_o);
        end
    endtask

    task automatic test_preload();
        int dc, dn, rc; logic [31:0] rd, d, a; logic re, st, to;
        for (int i = 0; i < DEPTH; i++) begin
            d = $urandom;
            a = (32'(i) * 4) | (32'($urandom_range(0, 255)) << (AW + 2));
            access(1'b0, 1'b0, a, d, 0, dc, dn, rd, re, rc, st, to);
            model_write(a, 1'b0, d);
            n_cmp++;
            if (dc != L || re !== 1'b0 || to) begin
                n_err++;
                $display("FAIL preload_store[%0d]: got done_cycle=%0d err=%0b timeout=%0b, expected %0d/0/0",
                         i, dc, re, to, L);
            end
        end
    endtask

    task automatic test_store_load();
        int dc, dn, rc; logic [31:0] rd; logic re, st, to;
        access(1'b0, 1'b0, 32'h10, 32'hDEADBEEF, 0, dc, dn, rd, re, rc, st, to);
        model_write(32'h10, 1'b0, 32'hDEADBEEF);
        n_cmp++;
        if (dc != L || rc != L + 1) begin
            n_err++;
            $display("FAIL store_timing: got done_cycle=%0d ready_cycle=%0d, expected %0d/%0d", dc, rc, L, L + 1);
        end
        access(1'b1, 1'b0, 32'h10, 32'h0, 0, dc, dn, rd, re, rc, st, to);
        n_cmp++;
        if (dc != L || rc != L + 1) begin
            n_err++;
            $display("FAIL load_timing: got done_cycle=%0d ready_cycle=%0d, expected %0d/%0d", dc, rc, L, L + 1);
        end
        n_cmp++;
        if (rd !== 32'hDEADBEEF) begin
            n_err++;
            $display("FAIL load_word_data: got %h expected deadbeef", rd);
        end
    endtask

    task automatic test_byte_lanes();
        int dc, dn, rc; logic [31:0] rd; logic re, st, to;
        access(1'b0, 1'b0, 32'h10, 32'h11223344, 0, dc, dn, rd, re, rc, st, to);
        model_write(32'h10, 1'b0, 32'h11223344);
        access(1'b0, 1'b1, 32'h13, 32'hFFFFFF5A, 0, dc, dn, rd, re, rc, st, to);
        model_write(32'h13, 1'b1, 32'hFFFFFF5A);
        access(1'b1, 1'b0, 32'h10, 32'h0, 0, dc, dn, rd, re, rc, st, to);
        n_cmp++;
        if (rd !== 32'h5A223344) begin
            n_err++;
            $display("FAIL byte_store_merge: got %h expected 5a223344", rd);
        end
        access(1'b1, 1'b1, 32'h12, 32'h0, 0, dc, dn, rd, re, rc, st, to);
        n_cmp++;
        if (rd !== 32'h00000022) begin
            n_err++;
            $display("FAIL byte_load_lane2: got %h expected 00000022", rd);
        end
        access(1'b1, 1'b1, 32'h10, 32'h0, 0, dc, dn, rd, re, rc, st, to);
        n_cmp++;
        if (rd !== 32'h00000044) begin
            n_err++;
            $display("FAIL byte_load_lane0: got %h expected 00000044", rd);
        end
    endtask

    task automatic test_misaligned();
        int dc, dn, rc; logic [31:0] rd, old; logic re, st, to;
        old = model_read(32'h04, 1'b0);
        access(1'b1, 1'b0, 32'h06, 32'h0, 0, dc, dn, rd, re, rc, st, to);
        n_cmp++;
        if (dc != L || re !== 1'b1 || rd !== 32'd0) begin
            n_err++;
            $display("FAIL misaligned_load: got done_cycle=%0d err=%0b data=%h, expected %0d/1/0", dc, re, rd, L);
        end
        access(1'b0, 1'b0, 32'h06, 32'h12345678, 0, dc, dn, rd, re, rc, st, to);
        n_cmp++;
        if (dc != L || re !== 1'b1) begin
            n_err++;
            $display("FAIL misaligned_store: got done_cycle=%0d err=%0b, expected %0d/1", dc, re, L);
        end
        access(1'b1, 1'b0, 32'h04, 32'h0, 0, dc, dn, rd, re, rc, st, to);
        n_cmp++;
        if (rd !== old || re !== 1'b0) begin
            n_err++;
            $display("FAIL misaligned_no_write: got %h err=%0b expected %h err=0", rd, re, old);
        end
    endtask

    task automatic test_flush();
        int dc, dn, rc; logic [31:0] rd, d; logic re, st, to;
        access(1'b1, 1'b0, 32'h10, 32'h0, 1, dc, dn, rd, re, rc, st, to);
        n_cmp++;
        if (dn != 0 || rc != 2) begin
            n_err++;
            $display("FAIL flush_load_wait: got done_count=%0d ready_cycle=%0d, expected 0/2", dn, rc);
        end
        access(1'b1, 1'b0, 32'h10, 32'h0, L, dc, dn, rd, re, rc, st, to);
        n_cmp++;
        if (dn != 0 || rc != L + 1 || st) begin
            n_err++;
            $display("FAIL flush_load_resp: got done_count=%0d ready_cycle=%0d stray=%0b, expected 0/%0d/0",
                     dn, rc, st, L + 1);
        end
        d = $urandom;
        access(1'b0, 1'b0, 32'h14, d, 1, dc, dn, rd, re, rc, st, to);
        model_write(32'h14, 1'b0, d);
        n_cmp++;
        if (dc != L || dn != 1) begin
            n_err++;
            $display("FAIL flush_store_done: got done_cycle=%0d done_count=%0d, expected %0d/1", dc, dn, L);
        end
        access(1'b1, 1'b0, 32'h14, 32'h0, 0, dc, dn, rd, re, rc, st, to);
        n_cmp++;
        if (rd !== d) begin
            n_err++;
            $display("FAIL flush_store_commit: got %h expected %h", rd, d);
        end
    endtask

    task automatic test_wrap();
        int dc, dn, rc; logic [31:0] rd; logic re, st, to;
        access(1'b0, 1'b0, 32'h400, 32'hCAFEF00D, 0, dc, dn, rd, re, rc, st, to);
        model_write(32'h400, 1'b0, 32'hCAFEF00D);
        access(1'b1, 1'b0, 32'h000, 32'h0, 0, dc, dn, rd, re, rc, st, to);
        n_cmp++;
        if (rd !== 32'hCAFEF00D) begin
            n_err++;
            $display("FAIL addr_wrap: got %h expected cafef00d", rd);
        end
    endtask

    task automatic test_flush_idle();
        int w;
        w = 0;
        @(negedge clk_i);
        while (ready_o !== 1'b1 && w < 30) begin
            @(negedge clk_i);
            w++;
        end
        valid_i = 1'b1; flush_i = 1'b1; r_not_w_i = 1'b1; byte_i = 1'b0; data_addr_i = 32'h10;
        @(posedge clk_i); #1;
        valid_i = 1'b0; flush_i = 1'b0;
        for (int k = 1; k <= L + 1; k++) begin
            @(negedge clk_i);
            n_cmp++;
            if (ready_o !== 1'b1 || done_o !== 1'b0) begin
                n_err++;
                $display("FAIL flush_valid_idle[%0d]: got ready=%0b done=%0b expected 1/0", k, ready_o, done_o);
            end
        end
    endtask

    task automatic test_random();
        int dc, dn, rc, fc, exp_dc, exp_rc;
        logic [31:0] rd, addr, wd, exp_rd;
        logic re, st, to, rnw, byt, mis, fl;
        for (int i = 0; i < 200; i++) begin
            rnw  = 1'($urandom);
            byt  = 1'($urandom);
            addr = $urandom;
            if (!byt && $urandom_range(0, 3) != 0) addr = addr & ~32'h3;
            wd   = $urandom;
            fc   = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, L + 1)) : 0;
            mis  = !byt && (addr % 4 != 0);
            fl   = rnw && fc >= 1 && fc <= L;
            exp_rd = (rnw && !mis && !fl) ? model_read(addr, byt) : 32'd0;
            exp_dc = fl ? -1 : L;
            exp_rc = fl ? fc + 1 : L + 1;
            access(rnw, byt, addr, wd, fc, dc, dn, rd, re, rc, st, to);
            if (!rnw && !mis) model_write(addr, byt, wd);
            n_cmp++;
            if (to || dc != exp_dc || dn != (fl ? 0 : 1) || rc != exp_rc) begin
                n_err++;
                $display("FAIL rand_timing[%0d]: got to=%0b done_cycle=%0d count=%0d ready_cycle=%0d, expected 0/%0d/%0d/%0d",
                         i, to, dc, dn, rc, exp_dc, fl ? 0 : 1, exp_rc);
            end
            n_cmp++;
            if (rd !== exp_rd || re !== (!fl && mis) || st) begin
                n_err++;
                $display("FAIL rand_data[%0d] rnw=%0b byte=%0b addr=%h: got data=%h err=%0b stray=%0b, expected %h/%0b/0",
                         i, rnw, byt, addr, rd, re, st, exp_rd, !fl && mis);
            end
        end
    endtask

    task automatic test_reset_drop();
        int dc, dn, rc, w; logic [31:0] rd, a, old; logic re, st, to;
        for (int rcyc = 1; rcyc <= L; rcyc++) begin
            a   = 32'h20 + 32'(4 * (rcyc - 1));
            old = model_read(a, 1'b0);
            w   = 0;
            @(negedge clk_i);
            while (ready_o !== 1'b1 && w < 30) begin
                @(negedge clk_i);
                w++;
            end
            valid_i = 1'b1; r_not_w_i = 1'b0; byte_i = 1'b0; data_addr_i = a; data_i = 32'h1;
            @(posedge clk_i); #1;
            valid_i = 1'b0;
            repeat (rcyc - 1) begin
                @(posedge clk_i); #1;
            end
            reset_n_i = 1'b0;
            repeat (3) begin
                @(negedge clk_i);
                n_cmp++;
                if ({ready_o, done_o, err_o, data_o} !== 35'd0) begin
                    n_err++;
                    $display("FAIL reset_mid_access[%0d]: got ready=%0b done=%0b err=%0b data=%h, expected all 0",
                             rcyc, ready_o, done_o, err_o, data_o);
                end
                @(posedge clk_i); #1;
            end
            reset_n_i = 1'b1;
            @(negedge clk_i);
            n_cmp++;
            if (ready_o !== 1'b1) begin
                n_err++;
                $display("FAIL reset_mid_ready[%0d]: got ready=%0b expected 1", rcyc, ready_o);
            end
            access(1'b1, 1'b0, a, 32'h0, 0, dc, dn, rd, re, rc, st, to);
            n_cmp++;
            if (rd !== old || dc != L) begin
                n_err++;
                $display("FAIL reset_drops_store[%0d]: got %h done_cycle=%0d, expected %h/%0d", rcyc, rd, dc, old, L);
            end
        end
    endtask

    initial begin
        n_cmp       = 0;
        n_err       = 0;
        reset_n_i   = 1'b0;
        valid_i     = 1'b0;
        r_not_w_i   = 1'b0;
        byte_i      = 1'b0;
        data_addr_i = 32'd0;
        data_i      = 32'd0;
        flush_i     = 1'b0;
        for (int i = 0; i < DEPTH; i++) mm[i] = 32'd0;

        test_reset();
        test_preload();
        test_store_load();
        test_byte_lanes();
        test_misaligned();
        test_flush();
        test_wrap();
        test_flush_idle();
        test_random();
        test_reset_drop();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/data_memory_ctrl.md
DATA_MEMORY_CTRL -- requirements
Module: data_memory_ctrl

Interface
REQ-001 Parameter DEPTH, default 256: number of 32-bit words in the array; power of two, 16..4096.
REQ-002 Parameter LATENCY, default 2: cycles from request accept to completion pulse; legal range 1..7.
REQ-003 clk_i  input  1  sole clock; all state updates on rising edge.
REQ-004 reset_n_i  input  1  synchronous active-low reset, sampled on rising edge of clk_i.
REQ-005 valid_i  input  1  memory-stage request present this cycle.
REQ-006 r_not_w_i  input  1  1 = load, 0 = store.
REQ-007 byte_i  input  1  1 = byte access (LDRB/STRB), 0 = word access.
REQ-008 data_addr_i  input  32  byte address from the ALU result.
REQ-009 data_i  input  32  store data; byte stores use data_i[7:0].
REQ-010 flush_i  input  1  pipeline flush; cancels an accepted-but-incomplete load.
REQ-011 ready_o  output  1  block can accept a request this cycle.
REQ-012 done_o  output  1  one-cycle completion pulse for loads and stores.
REQ-013 data_o  output  32  load result; valid only while done_o=1 and the request was a load.
REQ-014 err_o  output  1  one-cycle pulse with done_o for a misaligned word access.

Function
REQ-015 FSM states: IDLE, WAIT, RESP.
REQ-016 ready_o SHALL be 1 only in IDLE; a request is accepted when valid_i=1, ready_o=1 and flush_i=0.
REQ-017 On accept, latch r_not_w_i, byte_i, data_addr_i and data_i; later changes on these inputs SHALL have no effect.
REQ-018 LATENCY=1: IDLE goes directly to RESP. Otherwise IDLE goes to WAIT, and a down-counter holds WAIT for LATENCY-1 cycles before RESP.
REQ-019 RESP lasts exactly one cycle, asserts done_o, then returns to IDLE; done_o therefore rises exactly LATENCY cycles after the accept edge.
REQ-020 Word index = addr[log2(DEPTH)+1:2]; upper address bits are ignored, so addresses wrap modulo DEPTH*4.
REQ-021 Word load: data_o = the full word. Byte load: data_o = zero-extended byte from lane addr[1:0], where lane 0 = bits [7:0] (little-endian).
REQ-022 Word store writes all 32 bits; byte store writes only lane addr[1:0]; other lanes are unchanged.
REQ-023 Store commits to the array on the rising edge that ends the RESP cycle, so a load accepted on the next cycle returns the new data.
REQ-024 Word access with addr[1:0]!=0: no array write, data_o=0, err_o=1 together with done_o.
REQ-025 flush_i=1 in WAIT or RESP on a load: return to IDLE next cycle with no done_o pulse.
REQ-026 flush_i on a store: ignored; the store completes normally.
REQ-027 valid_i while not in IDLE: ignored and not queued; the requester must hold the request until ready_o=1.
REQ-028 flush_i and valid_i together in IDLE: request not accepted.
REQ-029 data_o SHALL be 0 whenever done_o=0 or the completing request was a store.

Reset
REQ-030 While reset_n_i=0: state = IDLE, counter = 0, ready_o=0, done_o=0, err_o=0, data_o=0.
REQ-031 ready_o SHALL rise in the first cycle after reset_n_i returns to 1.
REQ-032 Reset during WAIT or RESP drops the pending request; a pending store SHALL NOT be committed.
REQ-033 Array contents are not cleared by reset.

Verification
REQ-034 LATENCY=2: store word 0xDEADBEEF to 0x10, then load 0x10 -> each done_o exactly 2 cycles after its accept; load data_o=0xDEADBEEF; ready_o=0 for 2 cycles per access.
REQ-035 Store byte 0x5A to 0x13 over word 0x11223344 -> word load from 0x10 returns 0x5A223344; byte load from 0x12 returns 0x00000022.
REQ-036 Word load from 0x06 -> err_o=1 with done_o; data_o=0. Word store to 0x06 -> err_o=1 with done_o; word at 0x04 unchanged.
REQ-037 Load accepted, flush_i=1 in the following cycle -> no done_o; ready_o=1 the cycle after the flush. Same sequence for a store -> store commits and done_o pulses.
REQ-038 DEPTH=256: store 0xCAFEF00D to 0x400 -> load from 0x000 returns 0xCAFEF00D (address wrap).
REQ-039 Store 0x1 to 0x20, pull reset_n_i low during WAIT -> after reset all outputs are 0 and a load from 0x20 returns the prior contents, not 0x1.
